// File: rtl/data_memory_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_dump_reader_pkg
// Description : Shared types and constants for the data memory dump reader:
//               FSM state encoding, memory trunk mode codes and the
//               word-index to byte-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_memory_dump_reader_pkg;

    // Trunk mode codes understood by the data memory access block
    localparam logic [1:0] TRUNK_MODE_WORD = 2'b00;
    localparam logic [1:0] TRUNK_MODE_HALF = 2'b01;
    localparam logic [1:0] TRUNK_MODE_BYTE = 2'b10;

    // Dump FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_FINISH  = 3'd5
    } dump_state_t;

    // Word index to byte address: words are 4 bytes, so shift left by two
    function automatic logic [31:0] word_to_byte(input logic [31:0] word_idx);
        return {word_idx[29:0], 2'b00};
    endfunction

endpackage : data_memory_dump_reader_pkg
`default_nettype wire

// File: rtl/data_memory_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_dump_reader_if
// Description : Memory access port and output word stream of the dump
//               reader. The master side is the reader, the slave side is
//               the memory block plus the transmit-path consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_dump_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Memory access port
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_trunk_mode;
    logic              mem_shift_to_trunk;
    logic [DATA_W-1:0] mem_rdata;

    // Output word stream (valid/ready)
    logic [DATA_W-1:0] dout_data;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_trunk_mode,
        output mem_shift_to_trunk,
        input  mem_rdata,
        output dout_data,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_trunk_mode,
        input  mem_shift_to_trunk,
        output mem_rdata,
        input  dout_data,
        input  dout_valid,
        output dout_ready
    );

endinterface : data_memory_dump_reader_if
`default_nettype wire

// File: rtl/data_memory_dump_reader_dump_latency_counter.sv
`default_nettype none
// ============================================================================
// Module      : dump_latency_counter
// Description : Read-latency down counter. Loaded with READ_LAT-1 when a read
//               is issued, decremented while waiting; zero_next flags that
//               the current decrement brings the count to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dump_latency_counter #(
    parameter int READ_LAT = 1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic load,
    input  wire logic dec,
    output logic      zero_next
);

    localparam int CNT_W = 2;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load has priority, decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(READ_LAT - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A decrement from one lands on zero, so the data is ready next cycle
    always_comb begin
        zero_next = (cnt_q == CNT_W'(1));
    end

endmodule : dump_latency_counter
`default_nettype wire

// File: rtl/data_memory_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_dump_reader
// Description : Walks a range of word-aligned data memory addresses, issues
//               one read per word and streams each returned word out over a
//               valid/ready port. Owns the memory port only while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_dump_reader
    import data_memory_dump_reader_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         ADDR_W      = 32,
    parameter int         WORD_ADDR_W = 10,
    parameter int         READ_LAT    = 1,
    parameter logic [1:0] TRUNK_WORD  = TRUNK_MODE_WORD
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   start,
    input  wire logic [WORD_ADDR_W-1:0] base_word,
    input  wire logic [WORD_ADDR_W:0]   word_count,
    input  wire logic                   abort,
    output logic                        busy,
    output logic                        done,
    data_memory_dump_reader_if.master   bus
);

    dump_state_t             state_q,       state_d;
    logic [WORD_ADDR_W-1:0]  idx_q,         idx_d;
    logic [WORD_ADDR_W:0]    remaining_q,   remaining_d;
    logic [DATA_W-1:0]       dout_data_q,   dout_data_d;
    logic                    abort_pend_q,  abort_pend_d;

    logic lat_load;
    logic lat_dec;
    logic lat_zero_next;

    dump_latency_counter #(
        .READ_LAT (READ_LAT)
    ) u_lat_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (lat_load),
        .dec       (lat_dec),
        .zero_next (lat_zero_next)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            remaining_q  <= '0;
            dout_data_q  <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            remaining_q  <= remaining_d;
            dout_data_q  <= dout_data_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        remaining_d  = remaining_q;
        dout_data_d  = dout_data_q;
        abort_pend_d = abort_pend_q;
        lat_load     = 1'b0;
        lat_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    idx_d       = base_word;
                    remaining_d = word_count;
                    state_d     = (word_count == '0) ? ST_FINISH : ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                lat_load = 1'b1;
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (READ_LAT == 1) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                lat_dec = 1'b1;
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (lat_zero_next) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                // An abort here drops the word before it is ever offered
                if (abort) begin
                    state_d = ST_FINISH;
                end else begin
                    dout_data_d = bus.mem_rdata;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                // The pending word always completes; an abort is remembered
                // until the handshake and then ends the dump
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (bus.dout_ready) begin
                    idx_d       = idx_q + WORD_ADDR_W'(1);
                    remaining_d = remaining_q - (WORD_ADDR_W + 1)'(1);
                    if ((remaining_q == (WORD_ADDR_W + 1)'(1)) || abort || abort_pend_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_FINISH: begin
                abort_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        bus.mem_read           = (state_q == ST_ISSUE);
        bus.mem_write          = 1'b0;
        bus.mem_trunk_mode     = TRUNK_WORD;
        bus.mem_shift_to_trunk = 1'b1;
        bus.mem_addr           = '0;
        if ((state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE)) begin
            bus.mem_addr = ADDR_W'(word_to_byte(32'(idx_q)));
        end
        bus.dout_data  = dout_data_q;
        bus.dout_valid = (state_q == ST_SEND);
        busy           = (state_q != ST_IDLE);
        done           = (state_q == ST_FINISH);
    end

endmodule : data_memory_dump_reader
`default_nettype wire

// File: doc/data_memory_dump_reader.md
Name: data_memory_dump_reader

Overview:
- Read-side initiator for the data memory access block. It walks a range of word-aligned data memory addresses and issues one read per word.
- Each returned word is captured and presented on a valid/ready output stream that feeds the debug/UART transmit path.
- It owns the memory access port only while the pipeline is halted (busy asserted). Arbitration is done outside this block.

Parameters:
- DATA_W, 32, data word width; matches the memory data bus.
- ADDR_W, 32, byte address width driven to the memory block.
- WORD_ADDR_W, 10, memory depth in words (log2); 1024 words.
- READ_LAT, 1, cycles from address presentation to valid read data (block RAM, registered read). Legal range 1..3.
- TRUNK_WORD, 2'b00, trunk mode code that selects full-word access.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a dump; ignored while busy
- base_word  in  WORD_ADDR_W  first word index, sampled on start
- word_count  in  WORD_ADDR_W+1  number of words (0..1024), sampled on start
- abort  in  1  ends the dump at the next state boundary
- mem_read  out  1  read strobe to memory block
- mem_write  out  1  always 0
- mem_addr  out  ADDR_W  byte address = {word_index, 2'b00}, zero-extended
- mem_trunk_mode  out  2  constant TRUNK_WORD
- mem_shift_to_trunk  out  1  constant 1 (word-indexed addressing)
- mem_rdata  in  DATA_W  read data from memory block
- dout_data  out  DATA_W  captured word
- dout_valid  out  1  dout_data is valid
- dout_ready  in  1  consumer accepts a word when valid&&ready
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the dump ends (normally or by abort)

Behaviour:
- Reset values: all outputs 0 except mem_shift_to_trunk=1 and mem_trunk_mode=TRUNK_WORD. FSM returns to IDLE and counters clear. Reset mid-dump drops the in-flight word with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, SEND, FINISH.
- IDLE:
  - start=1 latches idx=base_word and remaining=word_count.
  - Go to FINISH if word_count==0, else ISSUE.
- ISSUE:
  - mem_read=1 and mem_addr driven from idx for exactly this cycle.
  - Load lat_cnt=READ_LAT-1.
  - Go to CAPTURE if READ_LAT==1, else WAIT.
- WAIT: mem_addr is held. Decrement lat_cnt; go to CAPTURE when it reaches 0.
- CAPTURE: register dout_data<=mem_rdata, set dout_valid=1, go to SEND.
- SEND:
  - dout_data is stable while dout_valid && !dout_ready.
  - On the handshake: dout_valid<=0, idx<=idx+1, remaining<=remaining-1.
  - Then go to FINISH if remaining==1, else ISSUE.
- FINISH: done=1 for one cycle, busy<=0, go to IDLE.
- Throughput: at most one word per (READ_LAT+2) cycles. No read is issued while a word is pending.
- idx wraps modulo 2^WORD_ADDR_W (1023 -> 0). word_count=1024 reads every word exactly once.
- abort:
  - Sampled in ISSUE, WAIT, CAPTURE and SEND.
  - In SEND the pending word still completes its handshake, then the FSM goes to FINISH.
  - In ISSUE/WAIT/CAPTURE the read in flight is discarded (dout_valid never rises), then FINISH.
  - abort in IDLE has no effect.
- start during busy: ignored. start and abort together in IDLE: the dump starts.
- mem_write is never asserted. The memory block's write-enable is MemWrite & ~MemRead, so reads can never corrupt memory.

Decomposition:
- Shared package: state encoding enum (6 states), TRUNK_WORD constant alongside the other trunk mode codes, and the word-to-byte address helper (shift left 2).
- One natural sub-module: dump_latency_counter (load/decrement/zero flag for READ_LAT). The rest stays in a single FSM.

Test Plan:
- base_word=0, word_count=4, memory preloaded 0x11111111..0x44444444, dout_ready=1 → four words in order. mem_addr sequence 0x000, 0x004, 0x008, 0x00C; one done pulse; busy low afterward.
- word_count=0 → done one cycle after IDLE sees start; mem_read never asserted; dout_valid stays 0.
- base_word=1022, word_count=3 → mem_addr 0xFF8, 0xFFC, then 0x000 (wrap); data matches words 1022, 1023, 0.
- dout_ready low for 5 cycles after the first dout_valid → dout_data held constant and no new mem_read during the stall; dump resumes when ready rises.
- abort asserted during WAIT with READ_LAT=3 on word 2 of 10 → only word 1 emitted, done pulses once, no further mem_read. Assert reset mid-SEND of a separate run → all outputs return to reset values and no done pulse.
- Throughout every run: mem_write==0, mem_shift_to_trunk==1, mem_trunk_mode==TRUNK_WORD.
